ddr_pattern_writer: RTL

Write-side client of the ddr2_mgr user port. It fills DDR2 rows 0..MAX_ROW with a known pattern: one burst request of XFR_LEN 32-bit words per row, at column 0, bank 0. It signals init_done when finished, which software copies into CW_CS[1] to start the read-and-verify path. Single clock domain (clk); ddr2_mgr provides the clock crossing.

---
 rtl/ddr_mgr_pkg.sv | 9 +
 rtl/ddr_pat_gen.sv | 11 +
 rtl/ddr_pattern_writer.sv | 109 ++++++++++
 3 files changed

// File: rtl/ddr_mgr_pkg.sv
// ddr_mgr_pkg: shared state encoding, address field widths and pattern constants for DDR2 clients
package ddr_mgr_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_XFER, ST_NEXT, ST_DONE} state_t;
  localparam int ROW_W = 13;
  localparam int COL_W = 10;
  localparam int BANK_W = 2;
  localparam logic [31:0] DEF_PATTERN = 32'hFDCB8610;
  localparam logic [9:0] XFR_LEN_PER_LINE = 10'h200;
endpackage

// File: rtl/ddr_pat_gen.sv
// ddr_pat_gen: pattern word for (row, word_cnt, mode), shared by writer and read-side checker
module ddr_pat_gen import ddr_mgr_pkg::*; #(
  parameter logic [31:0] PATTERN = DEF_PATTERN
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] word_cnt,
  input  logic             mode,
  output logic [31:0]      data
);
  assign data = mode ? {row, 9'h000, word_cnt} : PATTERN;
endmodule

// File: rtl/ddr_pattern_writer.sv
// ddr_pattern_writer: fills DDR2 rows 0..MAX_ROW with a known pattern through the ddr2_mgr write port
module ddr_pattern_writer import ddr_mgr_pkg::*; #(
  parameter logic [9:0]  XFR_LEN = XFR_LEN_PER_LINE,
  parameter logic [12:0] MAX_ROW = 13'h02FF,
  parameter logic [15:0] GRANT_TIMEOUT = 16'hFFFF,
  parameter logic [31:0] PATTERN = DEF_PATTERN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  output logic        wr_mem_req,
  output logic [24:0] wr_mem_addr,
  output logic [9:0]  wr_xfr_len,
  input  logic        wr_mem_grant,
  input  logic        wr_data_req,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        init_done,
  output logic [12:0] rows_written,
  output logic        timeout_err,
  output logic        proto_err
);
  state_t state;
  logic mode_q, start_ok, consume, last, adv, nxt_mode, active;
  logic [ROW_W-1:0] row, nxt_row;
  logic [COL_W-1:0] word_cnt, nxt_cnt;
  logic [15:0] tcnt;
  logic [31:0] gen_data;
  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
  assign consume = state == ST_XFER && wr_data_req;
  assign last = consume && word_cnt == XFR_LEN - 10'd1;
  assign adv = state == ST_NEXT && row != MAX_ROW;
  assign active = state inside {ST_REQ, ST_XFER, ST_NEXT};
  assign wr_mem_addr = {row, {COL_W{1'b0}}, {BANK_W{1'b0}}};
  // Lookahead values feed the generator so wr_data is ready the cycle after each consume
  always_comb begin
    nxt_row = start_ok ? '0 : adv ? row + 13'd1 : row;
    nxt_cnt = (start_ok || last) ? '0 : consume ? word_cnt + 10'd1 : word_cnt;
    nxt_mode = start_ok ? mode : mode_q;
  end
  ddr_pat_gen #(.PATTERN(PATTERN)) u_gen (
    .row(nxt_row),
    .word_cnt(nxt_cnt),
    .mode(nxt_mode),
    .data(gen_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      row <= '0;
      word_cnt <= '0;
      mode_q <= 1'b0;
      tcnt <= '0;
      wr_mem_req <= 1'b0;
      wr_xfr_len <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      init_done <= 1'b0;
      rows_written <= '0;
      timeout_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      row <= nxt_row;
      word_cnt <= nxt_cnt;
      mode_q <= nxt_mode;
      if (start_ok || active) wr_data <= gen_data;
      proto_err <= (proto_err && !start_ok) || (wr_data_req && state != ST_XFER) ||
                   (wr_mem_grant && state != ST_REQ);
      tcnt <= state == ST_REQ ? tcnt + {15'h0, tcnt != 16'hFFFF} : '0;
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state <= ST_REQ;
          wr_mem_req <= 1'b1;
          wr_xfr_len <= XFR_LEN;
          busy <= 1'b1;
          init_done <= 1'b0;
          rows_written <= '0;
          timeout_err <= 1'b0;
        end
        ST_REQ: if (wr_mem_grant) begin
          state <= ST_XFER;
          wr_mem_req <= 1'b0;
        end else if (tcnt == GRANT_TIMEOUT - 16'd1) begin
          state <= ST_IDLE;
          wr_mem_req <= 1'b0;
          wr_xfr_len <= '0;
          busy <= 1'b0;
          timeout_err <= 1'b1;
        end
        ST_XFER: if (last) begin
          state <= ST_NEXT;
          wr_xfr_len <= '0;
          rows_written <= rows_written + 13'd1;
        end
        ST_NEXT: if (row == MAX_ROW) begin
          state <= ST_DONE;
          busy <= 1'b0;
          init_done <= 1'b1;
        end else begin
          state <= ST_REQ;
          wr_mem_req <= 1'b1;
          wr_xfr_len <= XFR_LEN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
